// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and types for the pipelined RV32I/M control path:
// opcodes, ALU operation codes, immediate formats and writeback source selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int ALU_W = 4;
    localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLT   = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SLTU  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLL   = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRL   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA   = 4'd9;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // An all-zero bundle is a bubble.
    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             alu_src;
        logic             mdu_valid;
        logic             illegal;
        logic [ALU_W-1:0] alu_ctrl;
        logic [1:0]       mem_to_reg;
        logic [2:0]       mdu_op;
    } ctrl_t;

    typedef enum logic [1:0] {MDU_IDLE, MDU_ISSUE, MDU_WAIT} mdu_state_t;

    // Shared funct3 -> ALU mapping for the non-alternate R and I forms.
    function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_ctrl_decoder.sv
// Combinational ID-stage decode of op/funct3/funct7 into the control bundle.
// Illegal encodings collapse to a bubble with only the illegal flag set.
module rv_ctrl_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic [2:0] imm_src
);

    logic illegal;

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_MULDIV) begin
                    if (M_EXT != 0) begin
                        ctrl.mdu_valid = 1'b1;
                        ctrl.mdu_op    = funct3;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (funct7 == F7_BASE) begin
                    ctrl.alu_ctrl = alu_from_funct3(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl.alu_ctrl = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3);
                // Only the shift forms constrain funct7; elsewhere it is immediate bits.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) ctrl.alu_ctrl = ALU_SRA;
                    else if (funct7 != F7_BASE) illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
                illegal        = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
                illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.mem_to_reg = WB_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = WB_PC4;
                illegal         = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_PASSB;
                imm_src        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control: decoded bundle flows ID/EX -> EX/MEM -> MEM/WB, with a
// small FSM that launches M ops on the MDU and holds EX until the result is back.
module pipe_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int M_EXT      = 1,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  stall_id,
    input  logic                  flush_ex,
    input  logic                  mdu_done,
    output logic [2:0]            id_ImmSrc,
    output logic                  ex_ALUSrc,
    output logic                  ex_Branch,
    output logic                  ex_Jump,
    output logic [ALU_CTRL_W-1:0] ex_ALU_Control,
    output logic [2:0]            ex_mdu_op,
    output logic                  mdu_start,
    output logic                  stall_req,
    output logic                  ex_illegal,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  wb_RegWrite,
    output logic [1:0]            wb_Mem_to_Reg
);

    ctrl_t      id_ctrl;
    ctrl_t      idex_q, idex_d;
    logic       exmem_reg_write_q, exmem_reg_write_d;
    logic       exmem_mem_read_q, exmem_mem_read_d;
    logic       exmem_mem_write_q, exmem_mem_write_d;
    logic [1:0] exmem_mem_to_reg_q, exmem_mem_to_reg_d;
    logic       memwb_reg_write_q, memwb_reg_write_d;
    logic [1:0] memwb_mem_to_reg_q, memwb_mem_to_reg_d;
    mdu_state_t state_q, state_d;
    logic       idex_load;
    logic       m_launch;

    rv_ctrl_decoder #(.M_EXT(M_EXT)) u_dec (
        .op      (op),
        .funct3  (funct3),
        .funct7  (funct7),
        .ctrl    (id_ctrl),
        .imm_src (id_ImmSrc)
    );

    assign stall_req = (state_q != MDU_IDLE) && !mdu_done;
    assign mdu_start = (state_q == MDU_ISSUE) && idex_q.mdu_valid;
    assign idex_load = !stall_req && !flush_ex && !stall_id;
    assign m_launch  = idex_load && id_ctrl.mdu_valid;

    always_comb begin
        idex_d = idex_q;
        // A branch cannot resolve while EX holds an M op, so flush is moot under stall.
        if (!stall_req) begin
            idex_d = idex_load ? id_ctrl : '0;
        end

        exmem_reg_write_d  = 1'b0;
        exmem_mem_read_d   = 1'b0;
        exmem_mem_write_d  = 1'b0;
        exmem_mem_to_reg_d = WB_ALU;
        if (!stall_req) begin
            exmem_reg_write_d  = idex_q.reg_write;
            exmem_mem_read_d   = idex_q.mem_read;
            exmem_mem_write_d  = idex_q.mem_write;
            exmem_mem_to_reg_d = idex_q.mem_to_reg;
        end

        memwb_reg_write_d  = exmem_reg_write_q;
        memwb_mem_to_reg_d = exmem_mem_to_reg_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE:  if (m_launch) state_d = MDU_ISSUE;
            MDU_ISSUE, MDU_WAIT: begin
                if (mdu_done) state_d = m_launch ? MDU_ISSUE : MDU_IDLE;
                else          state_d = MDU_WAIT;
            end
            default:   state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q             <= '0;
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_read_q   <= 1'b0;
            exmem_mem_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= WB_ALU;
            memwb_reg_write_q  <= 1'b0;
            memwb_mem_to_reg_q <= WB_ALU;
            state_q            <= MDU_IDLE;
        end else begin
            idex_q             <= idex_d;
            exmem_reg_write_q  <= exmem_reg_write_d;
            exmem_mem_read_q   <= exmem_mem_read_d;
            exmem_mem_write_q  <= exmem_mem_write_d;
            exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
            memwb_reg_write_q  <= memwb_reg_write_d;
            memwb_mem_to_reg_q <= memwb_mem_to_reg_d;
            state_q            <= state_d;
        end
    end

    assign ex_ALUSrc      = idex_q.alu_src;
    assign ex_Branch      = idex_q.branch;
    assign ex_Jump        = idex_q.jump;
    assign ex_ALU_Control = ALU_CTRL_W'(idex_q.alu_ctrl);
    assign ex_mdu_op      = idex_q.mdu_op;
    assign ex_illegal     = idex_q.illegal;
    assign mem_MemRead    = exmem_mem_read_q;
    assign mem_MemWrite   = exmem_mem_write_q;
    assign wb_RegWrite    = memwb_reg_write_q;
    assign wb_Mem_to_Reg  = memwb_mem_to_reg_q;

endmodule
